// File: rtl/gf_arb_pkg.sv
// Shared constants and state encoding for the GF(2^163) multiplier arbiter.
package gf_arb_pkg;

    localparam int GF_WIDTH = 163;
    localparam int NREQ_MAX = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/gf_arb_pick.sv
// Combinational winner picker: round-robin from ptr+1, or fixed lowest-index when GF_ARB_FIXED_PRIO_EN.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller only consumes the result while idle.
module gf_arb_pick #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

`ifdef GF_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        any = 1'b0;
        idx = '0;
        gnt = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req[k]) begin
                any = 1'b1;
                idx = IW'(k);
            end
        end
        if (any) gnt[idx] = 1'b1;
    end
`else
    // The search starts one past the last winner, so the last winner is checked last.
    always_comb begin
        any = 1'b0;
        idx = '0;
        gnt = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!any && req[(int'(ptr) + k) % NREQ]) begin
                any = 1'b1;
                idx = IW'((int'(ptr) + k) % NREQ);
            end
        end
        if (any) gnt[idx] = 1'b1;
    end
`endif

endmodule

// File: rtl/gf_mult_arbiter.sv
// Shares one GF(2^163) multiplier among NREQ requesters; GF_ARB_FIXED_PRIO_EN selects fixed priority over round-robin.
// Latency: grant+operand register 1 cycle, result+req_done 1 cycle after m_done (2 cycles over the multiplier).
// Backpressure: requesters hold req_start until req_done; m_start is held until m_done is sampled.
module gf_mult_arbiter
    import gf_arb_pkg::*;
#(
    parameter int WIDTH = GF_WIDTH,
    parameter int NREQ  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_start,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic [NREQ-1:0]           req_done,
    output logic [WIDTH-1:0]          req_result,
    output logic                      m_start,
    output logic [WIDTH-1:0]          m_a,
    output logic [WIDTH-1:0]          m_b,
    input  logic                      m_done,
    input  logic [WIDTH-1:0]          m_result,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] ST_IDLE = 2'(ARB_IDLE);
    localparam logic [1:0] ST_BUSY = 2'(ARB_BUSY);
    localparam logic [1:0] ST_DONE = 2'(ARB_DONE);

    logic [1:0]       state;
    logic [IW-1:0]    rr_ptr;
    logic             pick_any;
    logic [NREQ-1:0]  pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

`ifdef GF_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    // Reset value NREQ-1 makes requester 0 the first one searched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= IW'(NREQ - 1);
        end else if (state == ST_IDLE && pick_any) begin
            rr_ptr <= pick_idx;
        end
    end
`endif

    gf_arb_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req (req_start),
        .ptr (rr_ptr),
        .any (pick_any),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                sel_a = sel_a | req_a[i*WIDTH +: WIDTH];
                sel_b = sel_b | req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            m_start    <= 1'b0;
            busy       <= 1'b0;
            req_done   <= '0;
            m_a        <= '0;
            m_b        <= '0;
            req_result <= '0;
            grant_id   <= '0;
        end else begin
            req_done <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        m_a      <= sel_a;
                        m_b      <= sel_b;
                        m_start  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (m_done) begin
                        req_result         <= m_result;
                        m_start            <= 1'b0;
                        req_done[grant_id] <= 1'b1;
                        state              <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // No arbitration here: the served requester is still dropping its start.
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    m_start <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf_mult_arbiter.sv
// Directed bench for gf_mult_arbiter with a carry-less multiplier model of configurable latency.
module tb_gf_mult_arbiter;

    localparam int WIDTH = 163;
    localparam int NREQ  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NREQ-1:0]         req_start = '0;
    logic [NREQ*WIDTH-1:0]   req_a = '0;
    logic [NREQ*WIDTH-1:0]   req_b = '0;
    logic [NREQ-1:0]         req_done;
    logic [WIDTH-1:0]        req_result;
    logic                    m_start;
    logic [WIDTH-1:0]        m_a;
    logic [WIDTH-1:0]        m_b;
    logic                    m_done;
    logic [WIDTH-1:0]        m_result;
    logic                    busy;
    logic [$clog2(NREQ)-1:0] grant_id;

    int   tests = 0;
    int   fails = 0;
    int   mul_lat = 5;
    int   mul_cnt;
    logic stray_done = 1'b0;
    logic model_done;

    always #5 clk = ~clk;

    gf_mult_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_start  (req_start),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_done   (req_done),
        .req_result (req_result),
        .m_start    (m_start),
        .m_a        (m_a),
        .m_b        (m_b),
        .m_done     (m_done),
        .m_result   (m_result),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    // Operands stay below 2^32, so no field reduction is needed.
    function automatic logic [WIDTH-1:0] clmul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) r = r ^ (a << i);
        end
        return r;
    endfunction

    assign model_done = m_start && (mul_cnt == mul_lat - 1);
    assign m_done     = model_done | stray_done;
    assign m_result   = clmul(m_a, m_b);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     mul_cnt <= 0;
        else if (m_start && !model_done) mul_cnt <= mul_cnt + 1;
        else                            mul_cnt <= 0;
    end

    always @(negedge clk) begin
        if ($countones(req_done) > 1) begin
            fails++;
            $display("FAIL onehot_done: req_done=%b, required at most one bit", req_done);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
        req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    task automatic wait_done(output logic [NREQ-1:0] seen, output int cyc);
        seen = '0;
        cyc  = 0;
        while (seen == '0 && cyc < 64) begin
            @(negedge clk);
            cyc++;
            seen = req_done;
        end
        if (seen == '0) begin
            tests++;
            fails++;
            $display("FAIL wait_done: no req_done within 64 cycles, required a pulse");
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_start  = '0;
        req_a      = '0;
        req_b      = '0;
        stray_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [NREQ-1:0] raise;
        logic [31:0]     a0, b0, a1, b1;
        int              lat;
        int              exp_grant;
        logic [31:0]     exp_res;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [NREQ-1:0] seen;
        logic [NREQ-1:0] exp_done;
        int              cyc;
        int              stray_cnt;
        vec_t            v;

`ifdef GF_ARB_FIXED_PRIO_EN
        vecs.push_back('{raise: 2'b11, a0: 32'h2, b0: 32'h3, a1: 32'h5, b1: 32'h3, lat: 5, exp_grant: 0, exp_res: 32'h6});
        vecs.push_back('{raise: 2'b01, a0: 32'h7, b0: 32'h7, a1: 32'h0, b1: 32'h0, lat: 1, exp_grant: 0, exp_res: 32'h15});
        vecs.push_back('{raise: 2'b01, a0: 32'hF, b0: 32'h3, a1: 32'h0, b1: 32'h0, lat: 3, exp_grant: 0, exp_res: 32'h11});
        vecs.push_back('{raise: 2'b00, a0: 32'h0, b0: 32'h0, a1: 32'h0, b1: 32'h0, lat: 2, exp_grant: 1, exp_res: 32'hF});
`else
        vecs.push_back('{raise: 2'b11, a0: 32'h2, b0: 32'h3, a1: 32'h5, b1: 32'h3, lat: 5, exp_grant: 0, exp_res: 32'h6});
        vecs.push_back('{raise: 2'b01, a0: 32'h7, b0: 32'h7, a1: 32'h0, b1: 32'h0, lat: 1, exp_grant: 1, exp_res: 32'hF});
        vecs.push_back('{raise: 2'b10, a0: 32'h0, b0: 32'h0, a1: 32'hF, b1: 32'h3, lat: 3, exp_grant: 0, exp_res: 32'h15});
        vecs.push_back('{raise: 2'b01, a0: 32'h6, b0: 32'h6, a1: 32'h0, b1: 32'h0, lat: 2, exp_grant: 1, exp_res: 32'h11});
        vecs.push_back('{raise: 2'b10, a0: 32'h0, b0: 32'h0, a1: 32'h9, b1: 32'h5, lat: 4, exp_grant: 0, exp_res: 32'h14});
        vecs.push_back('{raise: 2'b00, a0: 32'h0, b0: 32'h0, a1: 32'h0, b1: 32'h0, lat: 1, exp_grant: 1, exp_res: 32'h2D});
`endif

        // Reset state
        do_reset();
        check("reset m_start", m_start, 0);
        check("reset busy", busy, 0);
        check("reset req_done", req_done, 0);
        check("reset req_result", req_result, 0);
        check("reset grant_id", grant_id, 0);
        check("reset m_a", m_a, 0);

        // Single request, exact cycle timing: m_start cycles 1-5, req_done cycle 6
        set_op(0, 32'h2, 32'h3);
        mul_lat   = 5;
        req_start = 2'b01;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check($sformatf("single m_start c%0d", c), m_start, (c <= 5) ? 1 : 0);
            check($sformatf("single req_done c%0d", c), req_done, (c == 6) ? 2'b01 : 2'b00);
            if (c == 1) begin
                check("single m_a", m_a, 2);
                check("single m_b", m_b, 3);
                check("single busy", busy, 1);
            end
            if (c == 6) begin
                check("single result", req_result, 6);
                check("single grant_id", grant_id, 0);
                req_start = '0;
            end
        end

        // Stray m_done in IDLE is ignored
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        check("stray req_done", req_done, 0);
        check("stray busy", busy, 0);
        @(negedge clk);
        check("stray result", req_result, 6);
        check("stray m_start", m_start, 0);

        // Zero-wait multiplier, back-to-back with one IDLE gap
        set_op(0, 32'hA, 32'h3);
        mul_lat   = 1;
        req_start = 2'b01;
        @(negedge clk);
        check("zw m_start c1", m_start, 1);
        @(negedge clk);
        check("zw req_done c2", req_done, 2'b01);
        check("zw result", req_result, 32'h1E);
        req_start = '0;
        @(negedge clk);
        check("zw gap m_start", m_start, 0);
        check("zw gap busy", busy, 0);
        set_op(0, 32'hFF, 32'h2);
        req_start = 2'b01;
        @(negedge clk);
        check("zw2 m_start", m_start, 1);
        @(negedge clk);
        check("zw2 req_done", req_done, 2'b01);
        check("zw2 result", req_result, 32'h1FE);
        req_start = '0;
        @(negedge clk);

        // Start dropped during BUSY still completes
        set_op(1, 32'h9, 32'h5);
        mul_lat   = 4;
        req_start = 2'b10;
        @(negedge clk);
        req_start = '0;
        wait_done(seen, cyc);
        check("drop req_done", seen, 2'b10);
        check("drop result", req_result, 32'h2D);
        check("drop grant_id", grant_id, 1);
        @(negedge clk);

        // Reset in cycle 3 of an operation
        set_op(0, 32'h7, 32'h7);
        mul_lat   = 10;
        req_start = 2'b01;
        repeat (3) @(negedge clk);
        check("midrst pre m_start", m_start, 1);
        rst_n = 1'b0;
        #1;
        check("midrst m_start", m_start, 0);
        check("midrst busy", busy, 0);
        check("midrst req_done", req_done, 0);
        check("midrst result", req_result, 0);
        req_start = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        stray_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_done != '0) stray_cnt++;
        end
        check("midrst no done", stray_cnt, 0);
        set_op(1, 32'h3, 32'h3);
        mul_lat   = 2;
        req_start = 2'b10;
        wait_done(seen, cyc);
        check("postrst req_done", seen, 2'b10);
        check("postrst result", req_result, 32'h5);
        check("postrst latency", cyc, 3);
        req_start = '0;

        // Simultaneous requests and fairness from a fresh reset
        do_reset();
        foreach (vecs[i]) begin
            v       = vecs[i];
            mul_lat = v.lat;
            if (v.raise[0]) begin set_op(0, v.a0, v.b0); req_start[0] = 1'b1; end
            if (v.raise[1]) begin set_op(1, v.a1, v.b1); req_start[1] = 1'b1; end
            wait_done(seen, cyc);
            exp_done = NREQ'(1) << v.exp_grant;
            check($sformatf("vec%0d req_done", i), seen, exp_done);
            check($sformatf("vec%0d grant_id", i), grant_id, v.exp_grant);
            check($sformatf("vec%0d result", i), req_result, v.exp_res);
            req_start = req_start & ~seen;
            @(negedge clk);
            check($sformatf("vec%0d idle gap", i), busy, 0);
        end
        req_start = '0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
